// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer.
//   CTR_SNT/CTR_WNT/CTR_WT/CTR_ST : 2-bit direction counter codes
//   ctr_next(ctr, taken)          : saturating counter step (never wraps)
package btb_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not taken
  localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not taken
  localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) nxt = (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'b01;
    else       nxt = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/btb_target_ram.sv
// Target storage for the BTB: one PC_W-wide target per index.
// Write is synchronous on posedge clk; read is registered on negedge clk so
// the looked-up target is ready in the second half of the fetch cycle.
// The storage array itself has no reset; only the read register clears.
// Ports:
//   clk    in  1       clock
//   rst    in  1       async active-high reset of the read register
//   we     in  1       write enable (sampled at posedge)
//   waddr  in  ADDR_W  write index
//   wdata  in  DATA_W  target to store
//   raddr  in  ADDR_W  read index (sampled at negedge)
//   rdata  out DATA_W  registered read data
module btb_target_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = mem[raddr];
  end

  // The negedge read sits mid-cycle, so a posedge write at the end of the
  // same cycle is not yet visible: lookups see pre-update contents.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters for the
// fetch stage, plus the D/E redirect merge that feeds inst_rom.
// Optional feature macro: BTB_STATS_EN (adds saturating statistics counters).
// Ports:
//   CLK, RST                  clock / async active-high reset
//   flush                     synchronous invalidate-all (wins over update)
//   pcF                       fetch PC looked up every cycle
//   prepc, hit_predict,
//   pred_taken                lookup result (prepc valid in second half-cycle)
//   nextpcD/fail_predictD,
//   nextpcE/fail_predictE     stage redirects; nextpc/fail_predict merged (E wins)
//   upd_en, upd_pc, upd_target,
//   upd_taken, upd_jump       training from E-stage resolution
//   stat_lookups/hits/mispred (BTB_STATS_EN only) 32-bit saturating counters
module btb_predictor
  import btb_pkg::*;
#(
  parameter int         PC_W     = 13,
  parameter int         IDX_W    = 11,
  parameter logic [1:0] CTR_INIT = CTR_WT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  input  logic [PC_W-1:0] pcF,
  output logic [PC_W-1:0] prepc,
  output logic            hit_predict,
  output logic            pred_taken,
  input  logic [PC_W-1:0] nextpcD,
  input  logic            fail_predictD,
  input  logic [PC_W-1:0] nextpcE,
  input  logic            fail_predictE,
  output logic [PC_W-1:0] nextpc,
  output logic            fail_predict,
  input  logic            upd_en,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            upd_jump
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_hits,
  output logic [31:0]     stat_mispred
`endif
);

  localparam int TAG_W = PC_W - IDX_W;
  localparam int DEPTH = 1 << IDX_W;

  logic             valid_q [DEPTH];
  logic             valid_d [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [TAG_W-1:0] tag_d   [DEPTH];
  logic             jump_q  [DEPTH];
  logic             jump_d  [DEPTH];
  logic [1:0]       ctr_q   [DEPTH];
  logic [1:0]       ctr_d   [DEPTH];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             ram_wr_req;
  logic             ram_we;
  logic [PC_W-1:0]  r_target;

  assign lk_idx  = pcF[IDX_W-1:0];
  assign lk_tag  = pcF[PC_W-1:IDX_W];
  assign upd_idx = upd_pc[IDX_W-1:0];
  assign upd_tag = upd_pc[PC_W-1:IDX_W];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Lookup: flop fields are read combinationally, target comes from the
  // negedge-registered RAM read.
  assign hit_predict = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = hit_predict && (jump_q[lk_idx] || ctr_q[lk_idx][1]);
  assign prepc       = hit_predict ? r_target : '0;

  // Redirect merge: E-stage is older than D-stage, so it takes priority.
  assign nextpc       = fail_predictE ? nextpcE : nextpcD;
  assign fail_predict = fail_predictD | fail_predictE;

  always_comb begin
    valid_d    = valid_q;
    tag_d      = tag_q;
    jump_d     = jump_q;
    ctr_d      = ctr_q;
    ram_wr_req = 1'b0;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) valid_d[i] = 1'b0;
    end else if (upd_en) begin
      if (upd_hit) begin
        if (upd_jump) begin
          ctr_d[upd_idx] = CTR_ST;
          ram_wr_req     = 1'b1;
        end else begin
          ctr_d[upd_idx] = ctr_next(ctr_q[upd_idx], upd_taken);
          ram_wr_req     = upd_taken;
        end
      end else if (upd_taken) begin
        // Miss on a taken branch: allocate, evicting whatever aliases here.
        valid_d[upd_idx] = 1'b1;
        tag_d[upd_idx]   = upd_tag;
        jump_d[upd_idx]  = upd_jump;
        ctr_d[upd_idx]   = upd_jump ? CTR_ST : CTR_INIT;
        ram_wr_req       = 1'b1;
      end
    end
  end

  // The target RAM has no reset, so block writes while reset is held to keep
  // an in-flight update from landing.
  assign ram_we = ram_wr_req & ~RST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        jump_q[i]  <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      jump_q  <= jump_d;
      ctr_q   <= ctr_d;
    end
  end

  btb_target_ram #(
    .ADDR_W (IDX_W),
    .DATA_W (PC_W)
  ) u_target_ram (
    .clk   (CLK),
    .rst   (RST),
    .we    (ram_we),
    .waddr (upd_idx),
    .wdata (upd_target),
    .raddr (lk_idx),
    .rdata (r_target)
  );

`ifdef BTB_STATS_EN
  logic [31:0] lookups_q, lookups_d;
  logic [31:0] hits_q,    hits_d;
  logic [31:0] mispred_q, mispred_d;

  always_comb begin
    lookups_d = lookups_q;
    hits_d    = hits_q;
    mispred_d = mispred_q;
    if (flush) begin
      lookups_d = '0;
      hits_d    = '0;
      mispred_d = '0;
    end else begin
      if (lookups_q != 32'hFFFF_FFFF)                  lookups_d = lookups_q + 32'd1;
      if (hit_predict  && hits_q    != 32'hFFFF_FFFF)  hits_d    = hits_q + 32'd1;
      if (fail_predict && mispred_q != 32'hFFFF_FFFF)  mispred_d = mispred_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lookups_q <= '0;
      hits_q    <= '0;
      mispred_q <= '0;
    end else begin
      lookups_q <= lookups_d;
      hits_q    <= hits_d;
      mispred_q <= mispred_d;
    end
  end

  assign stat_lookups = lookups_q;
  assign stat_hits    = hits_q;
  assign stat_mispred = mispred_q;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor: a driver pushes the expected lookup/redirect
// response for each cycle into exp_q; a monitor pops and compares in the
// second half of the cycle, after the negedge target read.
module tb_btb_predictor;

  localparam int PC_W  = 13;
  localparam int IDX_W = 11;
  localparam int DEPTH = 1 << IDX_W;
  localparam int W     = 2 * PC_W + 3;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            flush = 1'b0;
  logic [PC_W-1:0] pcF = '0;
  logic [PC_W-1:0] prepc;
  logic            hit_predict;
  logic            pred_taken;
  logic [PC_W-1:0] nextpcD = '0;
  logic            fail_predictD = 1'b0;
  logic [PC_W-1:0] nextpcE = '0;
  logic            fail_predictE = 1'b0;
  logic [PC_W-1:0] nextpc;
  logic            fail_predict;
  logic            upd_en = 1'b0;
  logic [PC_W-1:0] upd_pc = '0;
  logic [PC_W-1:0] upd_target = '0;
  logic            upd_taken = 1'b0;
  logic            upd_jump = 1'b0;
`ifdef BTB_STATS_EN
  logic [31:0]     stat_lookups;
  logic [31:0]     stat_hits;
  logic [31:0]     stat_mispred;
`endif

  // clock / reset
  always #5 CLK = ~CLK;

  btb_predictor dut (
    .CLK           (CLK),
    .RST           (RST),
    .flush         (flush),
    .pcF           (pcF),
    .prepc         (prepc),
    .hit_predict   (hit_predict),
    .pred_taken    (pred_taken),
    .nextpcD       (nextpcD),
    .fail_predictD (fail_predictD),
    .nextpcE       (nextpcE),
    .fail_predictE (fail_predictE),
    .nextpc        (nextpc),
    .fail_predict  (fail_predict),
    .upd_en        (upd_en),
    .upd_pc        (upd_pc),
    .upd_target    (upd_target),
    .upd_taken     (upd_taken),
    .upd_jump      (upd_jump)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups  (stat_lookups),
    .stat_hits     (stat_hits),
    .stat_mispred  (stat_mispred)
`endif
  );

  // reference model: one record per index, counters as plain integers 0..3
  bit              m_valid  [DEPTH];
  int              m_tag    [DEPTH];
  bit              m_jump   [DEPTH];
  int              m_ctr    [DEPTH];
  logic [PC_W-1:0] m_target [DEPTH];

  logic [W-1:0] exp_q[$];
  logic         lk_valid = 1'b0;
  int           errors = 0;
  int           checks = 0;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_jump[i]  = 1'b0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic model_update(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt,
                              input logic taken, input logic jump);
    int idx;
    int tag;
    idx = int'(pc) % DEPTH;
    tag = int'(pc) / DEPTH;
    if (m_valid[idx] && m_tag[idx] == tag) begin
      if (jump) begin
        m_ctr[idx]    = 3;
        m_target[idx] = tgt;
      end else if (taken) begin
        m_ctr[idx]    = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
        m_target[idx] = tgt;
      end else begin
        m_ctr[idx]    = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
      end
    end else if (taken) begin
      m_valid[idx]  = 1'b1;
      m_tag[idx]    = tag;
      m_jump[idx]   = jump;
      m_ctr[idx]    = jump ? 3 : 2;
      m_target[idx] = tgt;
    end
  endtask

  // driver: one full cycle of stimulus, expected response pushed to exp_q
  task automatic step(input logic [PC_W-1:0] pc, input logic ue, input logic [PC_W-1:0] upc,
                      input logic [PC_W-1:0] utgt, input logic utk, input logic ujp,
                      input logic fl, input logic rs, input logic fd,
                      input logic [PC_W-1:0] npd, input logic fe, input logic [PC_W-1:0] npe);
    int              idx;
    int              tag;
    logic            eh;
    logic            et;
    logic [PC_W-1:0] ep;
    logic [PC_W-1:0] en;
    @(posedge CLK);
    #1;
    RST = rs; flush = fl; pcF = pc;
    upd_en = ue; upd_pc = upc; upd_target = utgt; upd_taken = utk; upd_jump = ujp;
    fail_predictD = fd; nextpcD = npd; fail_predictE = fe; nextpcE = npe;
    lk_valid = 1'b1;
    if (rs) model_reset();
    idx = int'(pc) % DEPTH;
    tag = int'(pc) / DEPTH;
    eh  = m_valid[idx] && (m_tag[idx] == tag);
    et  = eh && (m_jump[idx] || m_ctr[idx] >= 2);
    ep  = eh ? m_target[idx] : '0;
    en  = fe ? npe : npd;
    exp_q.push_back({eh, et, ep, en, fd | fe});
    if (!rs) begin
      if (fl) begin
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      end else if (ue) begin
        model_update(upc, utgt, utk, ujp);
      end
    end
  endtask

  task automatic lookup(input logic [PC_W-1:0] pc);
    step(pc, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic train(input logic [PC_W-1:0] upc, input logic [PC_W-1:0] tgt,
                       input logic tk, input logic jp);
    step(upc, 1'b1, upc, tgt, tk, jp, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  // scoreboard helpers
  task automatic chk1(input string nm, input logic act, input logic ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, ex, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, ex, $time);
    end
  endtask

  // monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge CLK);
      #1;
      if (lk_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL queue_underflow: got empty queue expected an entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk1("hit_predict", hit_predict, e[W-1]);
          chk1("pred_taken", pred_taken, e[W-2]);
          chkw("prepc", {19'b0, prepc}, {19'b0, e[W-3 -: PC_W]});
          chkw("nextpc", {19'b0, nextpc}, {19'b0, e[PC_W:1]});
          chk1("fail_predict", fail_predict, e[0]);
        end
      end
    end
  end

  logic [PC_W-1:0] pool [8];
  logic [31:0]     r;
  logic [31:0]     r2;
  logic [31:0]     r3;

  initial begin
    pool = '{13'h0123, 13'h0923, 13'h1123, 13'h0456, 13'h0457, 13'h1FFF, 13'h07FF, 13'h0800};
    model_reset();

    // reset held for two cycles
    step(13'h0123, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    step(13'h0123, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    lookup(13'h0123);

    // cond taken allocation, then hit with ctr=10
    train(13'h0123, 13'h0400, 1'b1, 1'b0);
    lookup(13'h0123);

    // not-taken training: 10 -> 01 -> 00, then stays 00
    train(13'h0123, 13'h0555, 1'b0, 1'b0);
    lookup(13'h0123);
    train(13'h0123, 13'h0555, 1'b0, 1'b0);
    lookup(13'h0123);
    train(13'h0123, 13'h0555, 1'b0, 1'b0);
    lookup(13'h0123);
    // one taken step from 00 must only reach 01
    train(13'h0123, 13'h0600, 1'b1, 1'b0);
    lookup(13'h0123);

    // alias eviction on the same index
    train(13'h0923, 13'h0777, 1'b1, 1'b0);
    lookup(13'h0123);
    lookup(13'h0923);

    // jump allocation and top index boundary
    train(13'h1FFF, 13'h0001, 1'b1, 1'b1);
    lookup(13'h1FFF);
    lookup(13'h07FF);

    // redirect merge
    step(13'h0000, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h0010, 1'b1, 13'h0020);
    step(13'h0000, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h0010, 1'b0, 13'h0020);
    step(13'h0000, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0010, 1'b1, 13'h0020);

    // reset mid-run clears everything until retrained
    step(13'h0923, 1'b1, 13'h0456, 13'h0111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    lookup(13'h0923);
    lookup(13'h1FFF);
    lookup(13'h0456);

    // flush with a same-cycle allocation: flush wins
    train(13'h0456, 13'h0222, 1'b1, 1'b0);
    lookup(13'h0456);
    step(13'h0456, 1'b1, 13'h0457, 13'h0333, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
`ifdef BTB_STATS_EN
    @(posedge CLK);
    #2;
    lk_valid = 1'b0; flush = 1'b0; upd_en = 1'b0;
    chkw("stat_lookups_after_flush", stat_lookups, 32'd0);
    chkw("stat_hits_after_flush", stat_hits, 32'd0);
    chkw("stat_mispred_after_flush", stat_mispred, 32'd0);
`endif
    lookup(13'h0456);
    lookup(13'h0457);

    // randomized traffic over an aliasing PC pool
    for (int n = 0; n < 3000; n++) begin
      logic [PC_W-1:0] pc;
      logic [PC_W-1:0] upc;
      r  = $urandom;
      r2 = $urandom;
      r3 = $urandom;
      pc  = ($urandom_range(0, 9) < 8) ? pool[r[2:0]] : r2[PC_W-1:0];
      upc = ($urandom_range(0, 9) < 9) ? pool[r[5:3]] : r3[PC_W-1:0];
      step(pc, ($urandom_range(0, 9) < 6), upc, r2[28:16], r[8], ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 199) == 0), ($urandom_range(0, 299) == 0),
           r[9], r3[28:16], r[10], r[23:11]);
    end

    @(posedge CLK);
    #1;
    lk_valid = 1'b0;
    RST = 1'b0; flush = 1'b0; upd_en = 1'b0;
    repeat (2) @(posedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
